// File: rtl/ring_buffer_mp_pkg.sv
// ring_buffer_mp_pkg
// Shared helpers for the multi-port ring buffer: index-width sizing and
// modular pointer arithmetic that works for any depth, including depths
// that are not a power of two.
// Arguments are carried at 32 bits. Callers zero-extend pointers of
// AddrWidth+1 bits or fewer and truncate the result back to AddrWidth.
package ring_buffer_mp_pkg;

    localparam int PtrArgWidth = 32;

    // Number of bits needed to index n distinct values. Never returns 0.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // (a + b) mod depth, assuming a < depth and b <= depth.
    function automatic logic [PtrArgWidth-1:0] mod_add(
        input logic [PtrArgWidth-1:0] a,
        input logic [PtrArgWidth-1:0] b,
        input logic [PtrArgWidth-1:0] depth
    );
        logic [PtrArgWidth-1:0] sum;
        sum = a + b;
        return (sum >= depth) ? (sum - depth) : sum;
    endfunction

    // (a - b) mod depth, assuming a < depth and b < depth.
    function automatic logic [PtrArgWidth-1:0] mod_sub(
        input logic [PtrArgWidth-1:0] a,
        input logic [PtrArgWidth-1:0] b,
        input logic [PtrArgWidth-1:0] depth
    );
        return (a >= b) ? (a - b) : (a + depth - b);
    endfunction

endpackage

// File: rtl/ring_buffer_mp_rd_check.sv
// ring_buffer_mp_rd_check
// One read port of the ring buffer. It computes the port's offset from the
// read pointer, decides whether the address lies inside the live window, and
// selects the stored entry. Addresses at or beyond Depth return zero.
// Ports:
//   raddr  absolute entry address requested by this port
//   rptr   current read pointer of the buffer
//   usage  current occupancy of the buffer
//   mem    full storage array (read-only view)
//   ready  address lies inside [rptr, rptr+usage) modulo Depth
//   rdata  stored entry at raddr, or zero when raddr is out of range
module ring_buffer_mp_rd_check
    import ring_buffer_mp_pkg::*;
#(
    parameter int  Depth  = 32,
    parameter type data_t = logic,
    localparam int AddrWidth = idx_width(Depth),
    localparam int CntWidth  = idx_width(Depth + 1)
) (
    input  logic [AddrWidth-1:0] raddr,
    input  logic [AddrWidth-1:0] rptr,
    input  logic [CntWidth-1:0]  usage,
    input  data_t [Depth-1:0]    mem,
    output logic                 ready,
    output data_t                rdata
);

    logic                 in_range;
    logic [AddrWidth-1:0] off;

    assign in_range = 32'(raddr) < 32'(Depth);
    // off is meaningless for out-of-range addresses; in_range masks it.
    assign off      = AddrWidth'(mod_sub(32'(raddr), 32'(rptr), 32'(Depth)));
    assign ready    = in_range && (CntWidth'(off) < usage);
    assign rdata    = in_range ? mem[raddr] : '0;

endmodule

// File: rtl/ring_buffer_mp.sv
// ring_buffer_mp
// Circular buffer with all-or-nothing burst writes of up to NumWrPorts
// entries per cycle, NumRdPorts independent random-access read ports into
// the live window, and a separate read-pointer advance that retires entries.
// Any depth >= 2 is supported; occupancy is tracked explicitly.
// Optional feature macro: RING_BUFFER_MP_FLUSH_EN adds flush_i, which drops
// every live entry (rptr jumps to wptr) while leaving memory contents intact.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   wvalid_i / wready_o   burst request / burst fits in free space
//   wcount_i, wdata_i     burst length (1..NumWrPorts), lane k -> wptr+k
//   rvalid_i / rready_o   per-port request / address is inside live window
//   raddr_i, rdata_o      per-port absolute address / combinational data
//   advance_i, step_i     retire up to step_i entries (clamped to usage)
//   flush_i               discard all entries (flush build only)
//   wptr_o, rptr_o        write / read pointers
//   usage_o, full_o, empty_o  occupancy and status
module ring_buffer_mp
    import ring_buffer_mp_pkg::*;
#(
    parameter int  Depth      = 32,
    parameter int  NumWrPorts = 2,
    parameter int  NumRdPorts = 2,
    parameter type data_t     = logic,
    localparam int AddrWidth  = idx_width(Depth),
    localparam int CntWidth   = idx_width(Depth + 1),
    localparam int WcntWidth  = idx_width(NumWrPorts + 1)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 wvalid_i,
    output logic                                 wready_o,
    input  logic [WcntWidth-1:0]                 wcount_i,
    input  data_t [NumWrPorts-1:0]               wdata_i,
    input  logic [NumRdPorts-1:0]                rvalid_i,
    output logic [NumRdPorts-1:0]                rready_o,
    input  logic [NumRdPorts-1:0][AddrWidth-1:0] raddr_i,
    output data_t [NumRdPorts-1:0]               rdata_o,
    input  logic                                 advance_i,
    input  logic [CntWidth-1:0]                  step_i,
`ifdef RING_BUFFER_MP_FLUSH_EN
    input  logic                                 flush_i,
`endif
    output logic [AddrWidth-1:0]                 wptr_o,
    output logic [AddrWidth-1:0]                 rptr_o,
    output logic [CntWidth-1:0]                  usage_o,
    output logic                                 full_o,
    output logic                                 empty_o
);

    data_t [Depth-1:0] mem_q;
    logic [AddrWidth-1:0] wptr_q, wptr_d;
    logic [AddrWidth-1:0] rptr_q, rptr_d;
    logic [CntWidth-1:0]  usage_q, usage_d;
    logic [CntWidth-1:0]  step_eff;
    logic [CntWidth-1:0]  wcount_acc;
    logic                 wcount_legal;
    logic                 room;
    logic                 wr_acc;
    logic [NumWrPorts-1:0][AddrWidth-1:0] lane_addr;

    assign wcount_legal = (wcount_i != '0) && (32'(wcount_i) <= 32'(NumWrPorts));

    // Free space is judged on the registered occupancy only; entries retired
    // in the same cycle do not make room for this cycle's burst.
    assign room = (32'(Depth) - 32'(usage_q)) >= 32'(wcount_i);

`ifdef RING_BUFFER_MP_FLUSH_EN
    assign wready_o = room && !flush_i;
`else
    assign wready_o = room;
`endif

    assign wr_acc     = wvalid_i && wready_o && wcount_legal;
    assign wcount_acc = wr_acc ? CntWidth'(wcount_i) : '0;

    // Clamped to usage_q, so entries written this cycle are never retired.
    assign step_eff = !advance_i ? '0 : ((step_i < usage_q) ? step_i : usage_q);

    always_comb begin
        for (int k = 0; k < NumWrPorts; k++) begin
            lane_addr[k] = AddrWidth'(mod_add(32'(wptr_q), 32'(k), 32'(Depth)));
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = AddrWidth'(mod_add(32'(rptr_q), 32'(step_eff), 32'(Depth)));
        usage_d = usage_q + wcount_acc - step_eff;
        if (wr_acc) begin
            wptr_d = AddrWidth'(mod_add(32'(wptr_q), 32'(wcount_i), 32'(Depth)));
        end
`ifdef RING_BUFFER_MP_FLUSH_EN
        // wready_o is already low, so no write lands; only the window collapses.
        if (flush_i) begin
            rptr_d  = wptr_q;
            usage_d = '0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            usage_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            usage_q <= usage_d;
            if (wr_acc) begin
                for (int k = 0; k < NumWrPorts; k++) begin
                    if (k < int'(wcount_i)) begin
                        mem_q[lane_addr[k]] <= wdata_i[k];
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < NumRdPorts; p++) begin : g_rd
        ring_buffer_mp_rd_check #(
            .Depth  (Depth),
            .data_t (data_t)
        ) u_rd_check (
            .raddr (raddr_i[p]),
            .rptr  (rptr_q),
            .usage (usage_q),
            .mem   (mem_q),
            .ready (rready_o[p]),
            .rdata (rdata_o[p])
        );

        a_raddr_hold: assert property (@(posedge clk_i) disable iff (rst_i)
            (rvalid_i[p] && !rready_o[p]) |=> (!rvalid_i[p] || $stable(raddr_i[p])));
    end

    assign wptr_o  = wptr_q;
    assign rptr_o  = rptr_q;
    assign usage_o = usage_q;
    assign empty_o = (usage_q == '0);
    assign full_o  = (32'(usage_q) == 32'(Depth));

    a_wcount_legal: assert property (@(posedge clk_i) disable iff (rst_i)
        wvalid_i |-> wcount_legal);

    a_wr_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (wvalid_i && !wready_o) |=>
            (!wvalid_i || ($stable(wcount_i) && $stable(wdata_i))));

endmodule

// File: tb/tb_ring_buffer_mp.sv
// tb_ring_buffer_mp
// Directed walk through the main scenarios of the ring buffer at Depth=6,
// four write lanes and two read ports, followed by a randomized run with
// occasional resets. A behavioural model (plain array plus integer pointers
// and occupancy, all arithmetic in modulo-Depth integers) predicts every
// output. Flush scenarios are exercised when RING_BUFFER_MP_FLUSH_EN is set.
module tb_ring_buffer_mp;

    localparam int D  = 6;
    localparam int NW = 4;
    localparam int NR = 2;

    typedef logic [7:0] byte_t;

    logic                  clk = 1'b0;
    logic                  rst_i;
    logic                  wvalid;
    logic                  wready;
    logic [2:0]            wcount;
    byte_t [NW-1:0]        wdata;
    logic [NR-1:0]         rvalid;
    logic [NR-1:0]         rready;
    logic [NR-1:0][2:0]    raddr;
    byte_t [NR-1:0]        rdata;
    logic                  advance;
    logic [2:0]            step;
    logic                  flush;
    logic [2:0]            wptr;
    logic [2:0]            rptr;
    logic [2:0]            usage;
    logic                  full;
    logic                  empty;

    ring_buffer_mp #(
        .Depth      (D),
        .NumWrPorts (NW),
        .NumRdPorts (NR),
        .data_t     (byte_t)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .wvalid_i  (wvalid),
        .wready_o  (wready),
        .wcount_i  (wcount),
        .wdata_i   (wdata),
        .rvalid_i  (rvalid),
        .rready_o  (rready),
        .raddr_i   (raddr),
        .rdata_o   (rdata),
        .advance_i (advance),
        .step_i    (step),
`ifdef RING_BUFFER_MP_FLUSH_EN
        .flush_i   (flush),
`endif
        .wptr_o    (wptr),
        .rptr_o    (rptr),
        .usage_o   (usage),
        .full_o    (full),
        .empty_o   (empty)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;

    byte_t m_mem [D];
    int    m_wptr, m_rptr, m_usage;
    logic  last_blocked;
    logic  last_rdy [NR];

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_vec++;
        if (got !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_mem[i] = '0;
        m_wptr  = 0;
        m_rptr  = 0;
        m_usage = 0;
    endtask

    task automatic set_idle();
        wvalid  = 1'b0;
        wcount  = 3'd1;
        wdata   = '0;
        rvalid  = '0;
        raddr   = '0;
        advance = 1'b0;
        step    = '0;
        flush   = 1'b0;
    endtask

    // Checks the combinational outputs for the current inputs, advances the
    // model by one edge, clocks the DUT and checks the registered state.
    task automatic tick();
        int    exp_wr, acc, se, ra, rdy;
        byte_t exp_rd;
        logic  fl;
        #1;
        fl = 1'b0;
`ifdef RING_BUFFER_MP_FLUSH_EN
        fl = flush;
`endif
        exp_wr = ((D - m_usage) >= int'(wcount) && !fl) ? 1 : 0;
        chk("wready", 32'(wready), exp_wr);
        for (int p = 0; p < NR; p++) begin
            ra     = int'(raddr[p]);
            rdy    = (ra < D && ((ra - m_rptr + D) % D) < m_usage) ? 1 : 0;
            exp_rd = (ra < D) ? m_mem[ra] : '0;
            chk($sformatf("rready%0d", p), 32'(rready[p]), rdy);
            chk($sformatf("rdata%0d", p), 32'(rdata[p]), int'(exp_rd));
            last_rdy[p] = (rdy != 0);
        end
        last_blocked = wvalid && (exp_wr == 0);

        if (rst_i) begin
            model_reset();
        end else if (fl) begin
            m_rptr  = m_wptr;
            m_usage = 0;
        end else begin
            acc = (wvalid && exp_wr != 0 && wcount >= 1 && int'(wcount) <= NW) ? 1 : 0;
            se  = advance ? ((int'(step) < m_usage) ? int'(step) : m_usage) : 0;
            if (acc != 0) begin
                for (int k = 0; k < int'(wcount); k++) m_mem[(m_wptr + k) % D] = wdata[k];
                m_wptr = (m_wptr + int'(wcount)) % D;
            end
            m_rptr  = (m_rptr + se) % D;
            m_usage = m_usage + (acc != 0 ? int'(wcount) : 0) - se;
        end

        @(posedge clk);
        #1;
        chk("usage", 32'(usage), m_usage);
        chk("wptr", 32'(wptr), m_wptr);
        chk("rptr", 32'(rptr), m_rptr);
        chk("empty", 32'(empty), (m_usage == 0) ? 1 : 0);
        chk("full", 32'(full), (m_usage == D) ? 1 : 0);
    endtask

    initial begin
        set_idle();
        rst_i = 1'b1;
        last_blocked = 1'b0;
        for (int p = 0; p < NR; p++) last_rdy[p] = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Reset state, idle, raddr 0/3.
        raddr[0] = 3'd0;
        raddr[1] = 3'd3;
        #1;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_usage", 32'(usage), 0);
        chk("rst_wready", 32'(wready), 1);
        chk("rst_rready", 32'(rready), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_ptrs", 32'({wptr, rptr}), 0);
        tick();

        // Burst A-D accepted.
        wvalid = 1'b1;
        wcount = 3'd4;
        wdata  = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        tick();
        chk("usage_after_abcd", 32'(usage), 4);

        // Burst of 3 blocked with only 2 free, then unblocked by advance 2.
        wcount = 3'd3;
        wdata  = {8'h00, 8'h33, 8'h22, 8'h11};
        tick();
        chk("blocked_wready", 32'(wready), 0);
        advance = 1'b1;
        step    = 3'd2;
        tick();
        chk("usage_after_adv2", 32'(usage), 2);
        advance = 1'b0;
        step    = '0;
        tick();
        chk("usage_after_unblock", 32'(usage), 5);

        // Drain, refill and drain again to bring wptr to 5 with an empty buffer.
        wvalid  = 1'b0;
        advance = 1'b1;
        step    = 3'd5;
        tick();
        wvalid  = 1'b1;
        wcount  = 3'd4;
        wdata   = {8'h44, 8'h43, 8'h42, 8'h41};
        advance = 1'b0;
        tick();
        wvalid  = 1'b0;
        advance = 1'b1;
        step    = 3'd4;
        tick();
        chk("wptr_before_wrap", 32'(wptr), 5);

        // Wrapping burst lands at 5, 0, 1.
        advance  = 1'b0;
        wvalid   = 1'b1;
        wcount   = 3'd3;
        wdata    = {8'h00, 8'h53, 8'h52, 8'h51};
        raddr[0] = 3'd0;
        raddr[1] = 3'd5;
        tick();
        chk("wptr_after_wrap", 32'(wptr), 2);
        wvalid = 1'b0;
        #1;
        chk("wrap_rready", 32'(rready), 3);
        chk("wrap_rdata0", 32'(rdata[0]), 8'h52);
        chk("wrap_rdata1", 32'(rdata[1]), 8'h51);
        tick();

        // Oversized step clamps to usage; same-cycle write survives.
        wvalid  = 1'b1;
        wcount  = 3'd2;
        wdata   = {8'h00, 8'h00, 8'h62, 8'h61};
        advance = 1'b1;
        step    = 3'd7;
        tick();
        chk("clamp_rptr", 32'(rptr), 2);
        chk("clamp_usage", 32'(usage), 2);
        chk("clamp_empty", 32'(empty), 0);

        // Move the window to rptr=4, usage=2, then probe its edges.
        wdata = {8'h00, 8'h00, 8'h72, 8'h71};
        step  = 3'd2;
        tick();
        wvalid   = 1'b0;
        advance  = 1'b0;
        step     = '0;
        raddr[0] = 3'd0;
        raddr[1] = 3'd5;
        #1;
        chk("window_rready", 32'(rready), 2);
        raddr[0] = 3'd5;
        raddr[1] = 3'd6;
        #1;
        chk("window_rready_oob", 32'(rready), 1);
        chk("oob_rdata", 32'(rdata[1]), 0);
        tick();

`ifdef RING_BUFFER_MP_FLUSH_EN
        // Fill to 5, then flush alongside a write and an advance.
        wvalid = 1'b1;
        wcount = 3'd3;
        wdata  = {8'h00, 8'h83, 8'h82, 8'h81};
        tick();
        chk("flush_pre_usage", 32'(usage), 5);
        wcount  = 3'd1;
        advance = 1'b1;
        step    = 3'd2;
        flush   = 1'b1;
        tick();
        chk("flush_usage", 32'(usage), 0);
        chk("flush_rptr", 32'(rptr), 3);
        chk("flush_wptr", 32'(wptr), 3);
        set_idle();
        tick();
`endif

        // Randomized run against the model.
        last_blocked = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rst_i = ($urandom_range(0, 99) == 0);
            if (!last_blocked) begin
                wvalid = ($urandom_range(0, 9) < 7);
                wcount = 3'($urandom_range(1, NW));
                for (int k = 0; k < NW; k++) wdata[k] = 8'($urandom);
            end
            advance = ($urandom_range(0, 9) < 4);
            step    = 3'($urandom_range(0, 7));
`ifdef RING_BUFFER_MP_FLUSH_EN
            flush   = ($urandom_range(0, 29) == 0);
`endif
            for (int p = 0; p < NR; p++) begin
                if (rvalid[p] && !last_rdy[p]) begin
                    rvalid[p] = $urandom_range(0, 1) != 0;
                end else begin
                    rvalid[p] = $urandom_range(0, 1) != 0;
                    raddr[p]  = 3'($urandom_range(0, 7));
                end
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ring_buffer_mp.md
# ring_buffer_mp

Multi-port successor to the single-port ring buffer: a circular buffer with burst writes of up to `NumWrPorts` entries per cycle, `NumRdPorts` independent restricted-random-access read ports and a decoupled read-pointer advance. It supports arbitrary (non-power-of-two) depth through an explicit occupancy counter. It sits between a producer (e.g. an instruction fetch or refill unit) and a consumer that re-reads in-flight entries before retiring them.

## Interface
- `Depth`, 32: number of entries, ≥ 2, any integer.
- `NumWrPorts`, 2: max entries written per cycle, 1..Depth.
- `NumRdPorts`, 2: independent read ports, ≥ 1.
- `data_t`, `logic`: entry type.
- Derived, not overridable:
  - `AddrWidth = idx_width(Depth)`
  - `CntWidth = idx_width(Depth+1)`
  - `WcntWidth = idx_width(NumWrPorts+1)`
- `clk_i  in  1  clock; the block uses one clock`.
- `rst_i  in  1  reset; synchronous and active-high`.
- `wvalid_i  in  1  write request`.
- `wready_o  out  1  burst accepted`.
- `wcount_i  in  WcntWidth  entries in burst, 1..NumWrPorts`.
- `wdata_i  in  NumWrPorts x data_t  lane k is written to wptr+k`.
- `rvalid_i  in  NumRdPorts  per-port read request`.
- `rready_o  out  NumRdPorts  per-port address valid`.
- `raddr_i  in  NumRdPorts x AddrWidth  per-port absolute address`.
- `rdata_o  out  NumRdPorts x data_t  per-port data`.
- `advance_i  in  1  retire entries`.
- `step_i  in  CntWidth  entries to retire`.
- `flush_i  in  1  discard all entries` (only with `RING_BUFFER_MP_FLUSH_EN`).
- `wptr_o`, `rptr_o  out  AddrWidth  pointers`.
- `usage_o  out  CntWidth  occupancy`.
- `full_o`, `empty_o  out  1  status`.

## Operation
- State: `mem_q[Depth]`, `wptr_q`, `rptr_q` (modulo `Depth`, range 0..Depth-1), `usage_q` (0..Depth).
- Modular add: `(a+b) >= Depth ? a+b-Depth : a+b`, computed at `AddrWidth+1` bits; no power-of-two assumption.
- Write: `wready_o = (Depth - usage_q) >= wcount_i`. The burst is all-or-nothing, with no partial acceptance.
  - On `wvalid_i && wready_o`: lanes 0..wcount_i-1 are stored at `wptr_q+k` mod Depth, wrapping mid-burst, and `wptr_q` advances by `wcount_i`.
- Advance: `step_eff = min(step_i, usage_q)`. Entries written in the same cycle cannot be retired. `rptr_q` advances by `step_eff`.
- `usage_d = usage_q + wcount_acc - step_eff`, where `wcount_acc` is 0 if the write is not accepted.
- Read port p: `off = (raddr_i[p] - rptr_q) mod Depth`.
  - `rready_o[p] = raddr_i[p] < Depth && off < usage_q`.
  - `rdata_o[p] = mem_q[raddr_i[p]]` when `raddr_i[p] < Depth`, else `'0`.
  - Ports are fully independent; identical addresses are allowed.
- Status: `empty_o = usage_q==0`, `full_o = usage_q==Depth`.
- `wcount_i == 0` or `> NumWrPorts` with `wvalid_i` is illegal; the write is ignored and an assertion fires.
- Reset (`rst_i` high at an edge): memory cleared to `'0`, pointers 0, usage 0. An in-flight burst or advance in the same cycle is discarded.

## Timing
- Write-to-read latency 1 cycle: an entry written at edge N is `rready` and readable after edge N.
- Read path is combinational from state; no read latency.
- Advance takes effect at the next edge. A read of a retired address drops `rready_o` the following cycle.
- Reset values:
  - `wready_o=1` (for any legal `wcount_i`)
  - `rready_o='0`
  - `rdata_o='0`
  - `wptr_o=rptr_o=0`
  - `usage_o=0`
  - `empty_o=1`, `full_o=0`
- Handshake stability: `wcount_i` and `wdata_i` must be held while `wvalid_i && !wready_o`. `raddr_i[p]` must be held while `rvalid_i[p] && !rready_o[p]`. Both are asserted.
- A simultaneous write and advance at full occupancy is allowed. `wready_o` uses `usage_q` and does not credit same-cycle retirement.

## Configuration
- `RING_BUFFER_MP_FLUSH_EN` defined:
  - The `flush_i` port exists.
  - When `flush_i` is high: `rptr_d = wptr_q`, `usage_d = 0`, and `wready_o` is forced low that cycle. Flush has priority over write and advance. Memory contents are retained.
- Undefined: no `flush_i` port and no flush logic.

## Structure
- `ring_buffer_mp_pkg`: the modular add/subtract functions, parametrised by width via an `AddrWidth+1`-bit argument.
- Sub-module `ring_buffer_mp_rd_check`: one instance per read port. It computes `off`, `rready_o[p]` and the bounds-guarded `rdata` select.
- Assertions use the common assertion macros with reset `rst_i`.

## Test plan
Configuration: Depth=6, NumWrPorts=4, NumRdPorts=2.
- Reset, then idle: `empty_o=1`, `usage_o=0`, `wready_o=1`, `rready_o=00` for raddr 0/3.
- Write burst of 4 (A–D), then a burst of 3: the first is accepted with `usage=4`. The second has `wready_o=0` (only 2 free), and stays blocked until `advance_i` with `step_i=2` sets usage to 2, then is accepted.
- Wrap: with wptr=5, write a burst of 3 → entries land at 5, 0, 1, `wptr_o=2`. Port0 raddr=0 and port1 raddr=5 both return ready with the correct data.
- Advance with `step_i=7` while usage=3 and a same-cycle write of 2: `rptr` moves by 3, `usage_o=2`, `empty_o=0`.
- Read just past the window: usage=2 at rptr=4, raddr=0 → `rready_o=0`. raddr=5 → ready. raddr=6 (≥Depth) → not ready, `rdata=0`.
- With FLUSH_EN: at usage=5, assert `flush_i` together with a write and an advance → `usage_o=0`, `rptr_o=wptr_o` (unchanged), write not accepted.
